serial_add_arb: RTL and testbench

Shares one bit-serial add datapath between two requesters. The datapath is a full-add slice built from two half-add stages plus a carry flop. The block arbitrates round-robin, captures the winning requester's W-bit operands, and sequences the slice LSB-first over W cycles. It then presents the W-bit sum and carry-out tagged with the owner. It sits between the arithmetic datapath and two clients that need occasional additions but cannot each afford a parallel adder.

---
 rtl/serial_add_arb.sv | 126 ++++++++++++
 tb/tb_serial_add_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arb.sv
// serial_add_arb: two-requester round-robin front end around one
// bit-serial full-add slice. Operands are captured on grant, added
// LSB-first over W cycles, and the W-bit sum plus carry-out is presented
// for one cycle tagged with the requester that owns it.
module serial_add_arb #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         valid,
    output logic         owner,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            last;      // index of the requester served most recently
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    acc;       // sum bits assembled from the MSB side
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            own;       // owner of the operation in flight

    logic            h;
    logic            g;
    logic            s;
    logic            p;
    logic            carry_next;
    logic [W-1:0]    acc_next;

    // Round-robin grant: only in IDLE and out of reset; ties go to the
    // requester that was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && rst_n) begin
            gnt0 = req0 && (!req1 || last);
            gnt1 = req1 && (!req0 || !last);
        end
        busy = (state != IDLE);
    end

    // Full-add slice made of two half-add stages on the current LSBs.
    always_comb begin
        h          = a_sh[0] ^ b_sh[0];
        g          = a_sh[0] & b_sh[0];
        s          = h ^ carry;
        p          = h & carry;
        carry_next = g | p;
        // Written as shift-then-overwrite so the W=1 build needs no slice.
        acc_next        = acc >> 1;
        acc_next[W-1]   = s;
    end

    // Sequencer: capture on grant, W bit-steps, one-cycle result pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            own   <= 1'b0;
            valid <= 1'b0;
            owner <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_sh  <= gnt1 ? a1 : a0;
                        b_sh  <= gnt1 ? b1 : b0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        own   <= gnt1;
                        last  <= gnt1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= DONE;
                        valid <= 1'b1;
                        sum   <= acc_next;
                        cout  <= carry_next;
                        owner <= own;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arb.sv
// Self-checking bench for serial_add_arb: a cycle-level reference model
// predicts grants, busy/valid and the held result every cycle; expected
// results are queued at grant time and popped when the result is due.
module tb_serial_add_arb;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         valid;
    logic         owner;
    logic [W-1:0] sum;
    logic         cout;

    // W=1 instance
    logic         s_req0;
    logic [0:0]   s_a0;
    logic [0:0]   s_b0;
    logic         s_req1;
    logic [0:0]   s_a1;
    logic [0:0]   s_b1;
    logic         s_gnt0;
    logic         s_gnt1;
    logic         s_busy;
    logic         s_valid;
    logic         s_owner;
    logic [0:0]   s_sum;
    logic         s_cout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    serial_add_arb #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid),
        .owner(owner), .sum(sum), .cout(cout)
    );

    serial_add_arb #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(s_req0), .a0(s_a0), .b0(s_b0),
        .req1(s_req1), .a1(s_a1), .b1(s_b1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy), .valid(s_valid),
        .owner(s_owner), .sum(s_sum), .cout(s_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t        m_st   = M_IDLE;
    logic           m_last = 1'b1;
    int             m_cnt  = 0;
    logic [W+1:0]   held   = '0;     // {owner, cout, sum}
    logic [W+1:0]   sb[$];

    always @(negedge clk) begin
        logic       e_g0;
        logic       e_g1;
        logic [W:0] t;
        e_g0 = (m_st == M_IDLE) && rst_n && req0 && (!req1 || m_last);
        e_g1 = (m_st == M_IDLE) && rst_n && req1 && (!req0 || !m_last);
        check("gnt", 32'({gnt1, gnt0}), 32'({e_g1, e_g0}));
        check("busy", 32'(busy), 32'(m_st != M_IDLE));
        check("valid", 32'(valid), 32'(m_st == M_DONE));
        if (m_st == M_DONE) begin
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else held = sb.pop_front();
        end
        check("result", 32'({owner, cout, sum}), 32'(held));

        if (!rst_n) begin
            m_st   = M_IDLE;
            m_last = 1'b1;
            held   = '0;
            sb.delete();
        end else begin
            case (m_st)
                M_IDLE: if (e_g0 || e_g1) begin
                    t = e_g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
                    sb.push_back({e_g1, t});
                    m_last = e_g1;
                    m_cnt  = 0;
                    m_st   = M_RUN;
                end
                M_RUN: begin
                    if (m_cnt == W - 1) m_st = M_DONE;
                    else m_cnt++;
                end
                default: m_st = M_IDLE;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int idx, output int gcyc);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if ((idx == 0 && gnt0) || (idx == 1 && gnt1)) break;
        end
        check($sformatf("gnt%0d_wait", idx), 32'(idx == 0 ? gnt0 : gnt1), 32'd1);
        gcyc = cyc;
    endtask

    task automatic wait_valid(output int vcyc);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (valid) break;
        end
        check("valid_wait", 32'(valid), 32'd1);
        vcyc = cyc;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_wait", 32'(busy), 32'd0);
        next_cycle();
    endtask

    int gc;
    int vc;
    int c0;
    bit got;

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b0; a1 = '0; b1 = '0;
        s_req0 = 1'b0; s_a0 = '0; s_b0 = '0;
        s_req1 = 1'b0; s_a1 = '0; s_b1 = '0;
        repeat (3) next_cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", 32'({owner, cout, sum}), 32'd0);
        rst_n = 1'b1;

        // both requesters held from reset: alternating grants every W+2 cycles
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
        req1 = 1'b1; a1 = 8'hA0; b1 = 8'h7F;
        c0 = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (gnt0 || gnt1) got = 1'b1;
            end
            check("t3_gnt_seen", 32'(got), 32'd1);
            check("t3_order", 32'(gnt1), 32'(k % 2));
            if (k == 0) c0 = cyc;
            else check("t3_gnt_cycle", 32'(cyc - c0), 32'(k * (W + 2)));
            next_cycle();
            if (k % 2 == 0) begin a0 = a0 + 8'h45; b0 = b0 ^ 8'hC3; end
            else begin a1 = a1 + 8'h19; b1 = b1 ^ 8'h5A; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();

        // single req0: 0x5A + 0x3C, valid W+1 cycles after grant
        req0 = 1'b1; a0 = 8'h5A; b0 = 8'h3C;
        wait_gnt(0, gc);
        next_cycle();
        req0 = 1'b0; a0 = '0; b0 = '0;
        wait_valid(vc);
        check("t1_latency", 32'(vc - gc), 32'(W + 1));
        check("t1_sum", 32'(sum), 32'h96);
        check("t1_cout", 32'(cout), 32'd0);
        check("t1_owner", 32'(owner), 32'd0);
        wait_idle();

        // req1: carry-out cases
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
        wait_gnt(1, gc);
        next_cycle();
        req1 = 1'b0;
        wait_valid(vc);
        check("t2a_sum", 32'(sum), 32'h00);
        check("t2a_cout", 32'(cout), 32'd1);
        check("t2a_owner", 32'(owner), 32'd1);
        wait_idle();
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
        wait_gnt(1, gc);
        next_cycle();
        req1 = 1'b0;
        wait_valid(vc);
        check("t2b_sum", 32'(sum), 32'hFE);
        check("t2b_cout", 32'(cout), 32'd1);
        wait_idle();

        // req1 arrives in cycle 3 of a req0 operation
        req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
        wait_gnt(0, gc);
        next_cycle();
        req0 = 1'b0;
        while (cyc < gc + 3) next_cycle();
        req1 = 1'b1; a1 = 8'h80; b1 = 8'h81;
        wait_gnt(1, vc);
        check("t4_gnt1_cycle", 32'(vc - gc), 32'(W + 2));
        next_cycle();
        req1 = 1'b0;
        wait_idle();

        // reset in cycle 5 of a RUN aborts the operation
        req0 = 1'b1; a0 = 8'h5A; b0 = 8'hA5;
        wait_gnt(0, gc);
        next_cycle();
        req0 = 1'b0;
        while (cyc < gc + 5) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_sum", 32'(sum), 32'd0);
        check("t5_cout", 32'(cout), 32'd0);
        repeat (W + 2) @(negedge clk);
        check("t5_no_valid", 32'(valid), 32'd0);
        next_cycle();
        req0 = 1'b1; a0 = 8'h80; b0 = 8'h80;
        wait_gnt(0, gc);
        next_cycle();
        req0 = 1'b0;
        wait_valid(vc);
        check("t5_sum_after", 32'(sum), 32'h00);
        check("t5_cout_after", 32'(cout), 32'd1);
        wait_idle();

        // W=1 instance: 1 + 1
        s_req0 = 1'b1; s_a0 = 1'b1; s_b0 = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (s_gnt0) got = 1'b1;
        end
        check("w1_gnt", 32'(got), 32'd1);
        gc = cyc;
        next_cycle();
        s_req0 = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (s_valid) got = 1'b1;
        end
        check("w1_valid", 32'(got), 32'd1);
        check("w1_latency", 32'(cyc - gc), 32'd2);
        check("w1_sum", 32'(s_sum), 32'd0);
        check("w1_cout", 32'(s_cout), 32'd1);
        check("w1_owner", 32'(s_owner), 32'd0);

        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
